// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the MIPS datapath.
// Sequences FETCH -> DECODE -> EXEC/MEM/WB (or BRANCH/JUMP/TRAP) and drives
// every datapath enable. Outputs are Moore-decoded from the state and the
// opcode latched in DECODE. FETCH also qualifies IRWrite/PCWrite with MemReady.
// While Reset is high every output is held at 0.
//
// Handshake: MemRead/MemWrite (with MemSize) are requests that stay high and
// stable in FETCH/MEM until the cycle in which MemReady = 1; that cycle
// completes the transfer and the FSM advances on the following edge.
// MemReady is ignored in all other states.
//
// Optional feature macro: MULT_EN. When it is defined, opcode 011100 is
// decoded as `mul`, which spends MULT_CYCLES cycles in EXEC (counted by
// mulcnt) and drives ALUOp 1011. Without it, 011100 traps like any
// undefined opcode.
module main_control_fsm #(
   parameter int unsigned MULT_CYCLES = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic [3:0] ALUOp,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic [1:0] MemSize,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       ALUSrc,
   output logic       Branch,
   output logic       Jump,
   output logic       Link,
   output logic       Trap,
   output logic [2:0] debug_state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5,
      S_JUMP   = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_MUL    = 6'b011100;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] FN_JR     = 6'b001000;

   // A value outside 1..15 would either never leave EXEC or overflow mulcnt.
   if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
      $error("MULT_CYCLES must be in 1..15");
   end

   state_t     state;
   state_t     state_next;
   logic [5:0] op_q;

   // Instruction class flags of the latched opcode.
   logic is_load;
   logic is_store;
   logic is_imm;
   logic is_rtype;
   logic is_mul;

   assign is_load  = (op_q inside {OP_LB, OP_LH, OP_LW});
   assign is_store = (op_q inside {OP_SB, OP_SH, OP_SW});
   assign is_imm   = (op_q inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI});
   assign is_rtype = (op_q == OP_RTYPE);
`ifdef MULT_EN
   assign is_mul   = (op_q == OP_MUL);
`else
   assign is_mul   = 1'b0;
`endif

   assign debug_state = state;

   // Where DECODE sends the freshly fetched instruction.
   function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
      state_t t;
      t = S_TRAP;
      case (op)
         OP_RTYPE:                                    t = (fn == FN_JR) ? S_JUMP : S_EXEC;
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: t = S_BRANCH;
         OP_J, OP_JAL:                                t = S_JUMP;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:  t = S_EXEC;
         OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW:    t = S_EXEC;
`ifdef MULT_EN
         OP_MUL:                                      t = S_EXEC;
`endif
         default:                                     t = S_TRAP;
      endcase
      return t;
   endfunction

   // Operation class handed to the ALU control decoder.
   function automatic logic [3:0] aluop_of(input logic [5:0] op);
      logic [3:0] a;
      a = 4'b0000;
      case (op)
         OP_RTYPE:                                           a = 4'b0000;
         OP_ADDI, OP_LW, OP_SW, OP_LH, OP_SH, OP_LB, OP_SB:  a = 4'b0001;
         OP_XORI:                                            a = 4'b0010;
         OP_SLTI:                                            a = 4'b0011;
         OP_ANDI:                                            a = 4'b0100;
         OP_ORI:                                             a = 4'b0101;
         OP_REGIMM:                                          a = 4'b0110;
         OP_BGTZ:                                            a = 4'b0111;
         OP_BLEZ:                                            a = 4'b1000;
         OP_BNE:                                             a = 4'b1001;
         OP_BEQ:                                             a = 4'b1010;
`ifdef MULT_EN
         OP_MUL:                                             a = 4'b1011;
`endif
         default:                                            a = 4'b0000;
      endcase
      return a;
   endfunction

   // Access width: word/half/byte follows the low opcode bits of lw/lh/lb.
   function automatic logic [1:0] size_of(input logic [5:0] op);
      logic [1:0] s;
      case (op[1:0])
         2'b11:   s = 2'b00;
         2'b01:   s = 2'b01;
         default: s = 2'b10;
      endcase
      return s;
   endfunction

`ifdef MULT_EN
   localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);

   logic [3:0] mulcnt;
   logic       mul_done;

   assign mul_done = (mulcnt == MUL_LAST);

   // Counts mul cycles spent in EXEC; idle at zero otherwise.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mulcnt <= 4'd0;
      end else if (state == S_EXEC && is_mul && !mul_done) begin
         mulcnt <= mulcnt + 4'd1;
      end else begin
         mulcnt <= 4'd0;
      end
   end
`endif

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Opcode is captured only in DECODE so later Opcode changes are ignored.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         op_q <= 6'd0;
      end else if (state == S_DECODE) begin
         op_q <= Opcode;
      end
   end

   // Next-state and output decode; Reset forces every output to 0.
   always_comb begin
      state_next = state;
      ALUOp      = 4'b0000;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemSize    = 2'b00;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      ALUSrc     = 1'b0;
      Branch     = 1'b0;
      Jump       = 1'b0;
      Link       = 1'b0;
      Trap       = 1'b0;

      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            if (MemReady) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            state_next = decode_target(Opcode, Funct);
         end
         S_EXEC: begin
            ALUOp  = aluop_of(op_q);
            ALUSrc = is_imm || is_load || is_store;
            if (is_load || is_store) begin
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
`ifdef MULT_EN
            if (is_mul && !mul_done) begin
               state_next = S_EXEC;
            end
`endif
         end
         S_MEM: begin
            MemRead  = is_load;
            MemWrite = is_store;
            MemSize  = size_of(op_q);
            if (MemReady) begin
               state_next = is_load ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            RegWrite   = 1'b1;
            RegDst     = is_rtype || is_mul;
            MemToReg   = is_load;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            ALUOp      = aluop_of(op_q);
            Branch     = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            Jump       = 1'b1;
            Link       = (op_q == OP_JAL);
            RegWrite   = (op_q == OP_JAL);
            state_next = S_FETCH;
         end
         S_TRAP: begin
            Trap       = 1'b1;
            state_next = S_FETCH;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      if (Reset) begin
         ALUOp    = 4'b0000;
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         MemSize  = 2'b00;
         RegWrite = 1'b0;
         RegDst   = 1'b0;
         MemToReg = 1'b0;
         ALUSrc   = 1'b0;
         Branch   = 1'b0;
         Jump     = 1'b0;
         Link     = 1'b0;
         Trap     = 1'b0;
      end
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm. An instruction-level model expands each
// instruction into its per-cycle output timeline; a compare process checks
// the DUT against that timeline every cycle. MULT_EN selects mul behaviour.
module tb_main_control_fsm;

   localparam int MC = 3;

   // Clock / reset / DUT
   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] Opcode = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       MemReady = 1'b0;
   logic [3:0] ALUOp;
   logic       PCWrite, IRWrite, MemRead, MemWrite;
   logic [1:0] MemSize;
   logic       RegWrite, RegDst, MemToReg, ALUSrc, Branch, Jump, Link, Trap;
   logic [2:0] debug_state;

   always #5 Clk = ~Clk;

   main_control_fsm #(.MULT_CYCLES(MC)) dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
      .ALUOp(ALUOp), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemSize(MemSize), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump), .Link(Link),
      .Trap(Trap), .debug_state(debug_state)
   );

   // Output vector layout: {ALUOp, PCWrite, IRWrite, MemRead, MemWrite, MemSize,
   //                        RegWrite, RegDst, MemToReg, ALUSrc, Branch, Jump, Link, Trap}
   logic [17:0] act;
   assign act = {ALUOp, PCWrite, IRWrite, MemRead, MemWrite, MemSize,
                 RegWrite, RegDst, MemToReg, ALUSrc, Branch, Jump, Link, Trap};

   localparam logic [17:0] M_PCW  = 18'h02000;
   localparam logic [17:0] M_IRW  = 18'h01000;
   localparam logic [17:0] M_MR   = 18'h00800;
   localparam logic [17:0] M_MW   = 18'h00400;
   localparam logic [17:0] M_RW   = 18'h00080;
   localparam logic [17:0] M_RD   = 18'h00040;
   localparam logic [17:0] M_M2R  = 18'h00020;
   localparam logic [17:0] M_SRC  = 18'h00010;
   localparam logic [17:0] M_BR   = 18'h00008;
   localparam logic [17:0] M_J    = 18'h00004;
   localparam logic [17:0] M_LNK  = 18'h00002;
   localparam logic [17:0] M_TRAP = 18'h00001;

   function automatic logic [17:0] alu(input logic [3:0] a);
      return {a, 14'd0};
   endfunction

   function automatic logic [17:0] size(input logic [1:0] s);
      return {8'd0, s, 8'd0};
   endfunction

   // Scoreboard
   int          total = 0;
   int          bad = 0;
   logic [17:0] exp_q[$];
   string       tag_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Compare process: one expected vector per driven cycle.
   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         logic [17:0] e;
         string       t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, 32'(act), 32'(e));
      end
   end

   // Instruction-level model
   localparam int K_R = 0, K_IMM = 1, K_LOAD = 2, K_STORE = 3, K_MUL = 4;
   localparam int K_BR = 5, K_J = 6, K_JAL = 7, K_JR = 8, K_TRAP = 9;

   function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return (fn == 6'b001000) ? K_JR : K_R;
         6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: return K_BR;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return K_IMM;
         6'b100000, 6'b100001, 6'b100011: return K_LOAD;
         6'b101000, 6'b101001, 6'b101011: return K_STORE;
`ifdef MULT_EN
         6'b011100: return K_MUL;
`endif
         default: return K_TRAP;
      endcase
   endfunction

   function automatic logic [3:0] aluop_of(input logic [5:0] op);
      case (op)
         6'b000000: return 4'd0;
         6'b001000, 6'b100011, 6'b101011, 6'b100001, 6'b101001, 6'b100000, 6'b101000: return 4'd1;
         6'b001110: return 4'd2;
         6'b001010: return 4'd3;
         6'b001100: return 4'd4;
         6'b001101: return 4'd5;
         6'b000001: return 4'd6;
         6'b000111: return 4'd7;
         6'b000110: return 4'd8;
         6'b000101: return 4'd9;
         6'b000100: return 4'd10;
         6'b011100: return 4'd11;
         default:   return 4'd0;
      endcase
   endfunction

   function automatic logic [1:0] size_of(input logic [5:0] op);
      case (op)
         6'b100011, 6'b101011: return 2'b00;
         6'b100001, 6'b101001: return 2'b01;
         default:              return 2'b10;
      endcase
   endfunction

   typedef struct {
      logic        rst;
      logic        mr;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [17:0] exp;
      string       tag;
   } cyc_t;

   cyc_t plan[$];

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic add(input logic rst, input logic mr, input logic [5:0] opc,
                      input logic [5:0] fn, input logic [17:0] exp, input string tag);
      cyc_t c;
      c.rst = rst; c.mr = mr; c.opc = opc; c.fn = fn; c.exp = exp; c.tag = tag;
      plan.push_back(c);
   endtask

   // Expand one instruction into its cycle-by-cycle expected outputs.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                        input int mw, input string tag, output int n);
      int          k;
      int          start;
      int          nex;
      logic [17:0] ex;
      k = kind_of(op, fn);
      start = plan.size();
      for (int i = 0; i < fw; i++) add(1'b0, 1'b0, r6(), r6(), M_MR, tag);
      add(1'b0, 1'b1, r6(), r6(), M_MR | M_IRW | M_PCW, tag);
      add(1'b0, 1'($urandom_range(0, 1)), op, fn, 18'd0, tag);
      if (k == K_R || k == K_IMM || k == K_LOAD || k == K_STORE || k == K_MUL) begin
         nex = (k == K_MUL) ? MC : 1;
         ex = alu(aluop_of(op));
         if (k == K_IMM || k == K_LOAD || k == K_STORE) ex = ex | M_SRC;
         for (int i = 0; i < nex; i++) add(1'b0, 1'($urandom_range(0, 1)), r6(), r6(), ex, tag);
         if (k == K_LOAD || k == K_STORE) begin
            ex = ((k == K_LOAD) ? M_MR : M_MW) | size(size_of(op));
            for (int i = 0; i < mw; i++) add(1'b0, 1'b0, r6(), r6(), ex, tag);
            add(1'b0, 1'b1, r6(), r6(), ex, tag);
         end
         if (k != K_STORE) begin
            ex = M_RW;
            if (k == K_R || k == K_MUL) ex = ex | M_RD;
            if (k == K_LOAD) ex = ex | M_M2R;
            add(1'b0, 1'($urandom_range(0, 1)), r6(), r6(), ex, tag);
         end
      end else begin
         case (k)
            K_BR:    ex = alu(aluop_of(op)) | M_BR;
            K_JAL:   ex = M_J | M_LNK | M_RW;
            K_J:     ex = M_J;
            K_JR:    ex = M_J;
            default: ex = M_TRAP;
         endcase
         add(1'b0, 1'($urandom_range(0, 1)), r6(), r6(), ex, tag);
      end
      n = plan.size() - start;
   endtask

   // Driver: play the plan, optionally pinning one cycle to a literal value.
   task automatic play(input int pin_idx, input logic [17:0] pin_val, input string pin_name);
      for (int i = 0; i < plan.size(); i++) begin
         @(posedge Clk);
         #1;
         Reset    = plan[i].rst;
         MemReady = plan[i].mr;
         Opcode   = plan[i].opc;
         Funct    = plan[i].fn;
         exp_q.push_back(plan[i].exp);
         tag_q.push_back($sformatf("%s_c%0d", plan[i].tag, i));
         if (i == pin_idx) begin
            @(negedge Clk);
            check(pin_name, 32'(act), 32'(pin_val));
         end
      end
      plan.delete();
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int n;

      // Reset state: all outputs 0 while Reset is high.
      add(1'b1, 1'b1, r6(), r6(), 18'd0, "reset");
      add(1'b1, 1'b0, r6(), r6(), 18'd0, "reset");
      play(-1, 18'd0, "");

      // add: 4 cycles, WB in cycle 4.
      build(6'b000000, 6'b100000, 0, 0, "add", n);
      check("lat_add", 32'(n), 32'd4);
      play(3, M_RW | M_RD, "pin_add_wb");

      // lb with 3 wait cycles in MEM: 8 cycles total.
      build(6'b100000, 6'd0, 0, 3, "lb", n);
      check("lat_lb", 32'(n), 32'd8);
      play(6, M_MR | size(2'b10), "pin_lb_mem");

      // bne: branch one cycle with ALUOp 1001.
      build(6'b000101, 6'd0, 0, 0, "bne", n);
      check("lat_bne", 32'(n), 32'd3);
      play(2, alu(4'b1001) | M_BR, "pin_bne");

      // undefined opcode 111111: trap in cycle 3.
      build(6'b111111, 6'd0, 0, 0, "trap", n);
      check("lat_trap", 32'(n), 32'd3);
      play(2, M_TRAP, "pin_trap");

      // mul
      build(6'b011100, 6'd0, 0, 0, "mul", n);
`ifdef MULT_EN
      check("lat_mul", 32'(n), 32'(3 + MC));
      play(3, alu(4'b1011), "pin_mul_exec");
`else
      check("lat_mul", 32'(n), 32'd3);
      play(2, M_TRAP, "pin_mul_trap");
`endif

      // sw with fetch waits and one MEM wait.
      build(6'b101011, 6'd0, 2, 1, "sw", n);
      check("lat_sw", 32'(n), 32'd7);
      play(5, M_MW, "pin_sw_mem");

      // jal
      build(6'b000011, 6'd0, 0, 0, "jal", n);
      check("lat_jal", 32'(n), 32'd3);
      play(2, M_J | M_LNK | M_RW, "pin_jal");

      // Remaining classes with random wait cycles.
      vecs[0]  = '{6'b001000, 6'd0};  vecs[1]  = '{6'b001010, 6'd0};
      vecs[2]  = '{6'b001100, 6'd0};  vecs[3]  = '{6'b001101, 6'd0};
      vecs[4]  = '{6'b001110, 6'd0};  vecs[5]  = '{6'b100011, 6'd0};
      vecs[6]  = '{6'b100001, 6'd0};  vecs[7]  = '{6'b101001, 6'd0};
      vecs[8]  = '{6'b101000, 6'd0};  vecs[9]  = '{6'b000100, 6'd0};
      vecs[10] = '{6'b000110, 6'd0};  vecs[11] = '{6'b000111, 6'd0};
      vecs[12] = '{6'b000001, 6'd0};  vecs[13] = '{6'b000010, 6'd0};
      vecs[14] = '{6'b000000, 6'b001000};
      vecs[15] = '{6'b001001, 6'd0};
      for (int i = 0; i < 16; i++) begin
         build(vecs[i].op, vecs[i].fn, $urandom_range(0, 2), $urandom_range(0, 2),
               $sformatf("v%0d", i), n);
      end
      play(-1, 18'd0, "");

      // Reset held 2 cycles during a pending lw MEM wait aborts it.
      build(6'b100011, 6'd0, 0, 10, "lw_abort", n);
      while (plan.size() > 6) void'(plan.pop_back());
      add(1'b1, 1'b1, r6(), r6(), 18'd0, "abort_rst");
      add(1'b1, 1'b1, r6(), r6(), 18'd0, "abort_rst");
      play(-1, 18'd0, "");
      build(6'b000000, 6'b100101, 0, 0, "after_rst", n);
      play(0, M_MR | M_IRW | M_PCW, "pin_fetch_after_rst");

      @(negedge Clk);
      @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
